// File: rtl/rv32m_scheduler_pkg.sv
// Shared encodings for the RV32M scheduler slice.
//   M_* : RV32M operation codes carried on the M_CNT buses.
//   ST_*: scheduler FSM state encodings.
//   is_divrem / is_signed_divrem: classify an M_CNT code.
package rv32m_scheduler_pkg;

  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_FAST = 2'd2;

  function automatic logic is_divrem(input logic [2:0] m_cnt);
    return m_cnt[2];
  endfunction

  function automatic logic is_signed_divrem(input logic [2:0] m_cnt);
    return (m_cnt == M_DIV) || (m_cnt == M_REM);
  endfunction

endpackage

// File: rtl/rv32m_scheduler_m_special_case.sv
// Combinational detector for the RISC-V divide special cases that are
// answered without the multiply/divide unit.
//   M_CNT  : operation code
//   RS1/RS2: operands
//   HIT    : operation is a divide/remainder special case
//   RESULT : architectural result when HIT=1 (zero otherwise)
module m_special_case
  import rv32m_scheduler_pkg::*;
#(
  parameter int INPUT_WIDTH = 32
) (
  input  logic [2:0]             M_CNT,
  input  logic [INPUT_WIDTH-1:0] RS1,
  input  logic [INPUT_WIDTH-1:0] RS2,
  output logic                   HIT,
  output logic [INPUT_WIDTH-1:0] RESULT
);

  localparam logic signed [INPUT_WIDTH-1:0] MOST_NEG  = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
  localparam logic signed [INPUT_WIDTH-1:0] MINUS_ONE = '1;

  logic signed [INPUT_WIDTH-1:0] rs1_s;
  logic signed [INPUT_WIDTH-1:0] rs2_s;
  logic                          div_zero;
  logic                          overflow;

  assign rs1_s    = $signed(RS1);
  assign rs2_s    = $signed(RS2);
  assign div_zero = is_divrem(M_CNT) && (RS2 == '0);
  assign overflow = is_signed_divrem(M_CNT) && (rs1_s == MOST_NEG) && (rs2_s == MINUS_ONE);

  always_comb begin
    HIT    = 1'b0;
    RESULT = '0;
    if (div_zero) begin
      HIT    = 1'b1;
      RESULT = ((M_CNT == M_DIV) || (M_CNT == M_DIVU)) ? '1 : RS1;
    end else if (overflow) begin
      HIT    = 1'b1;
      RESULT = (M_CNT == M_DIV) ? MOST_NEG : '0;
    end
  end

endmodule

// File: rtl/rv32m_scheduler.sv
// Shares one RV32M multiply/divide unit between two requesters with
// round-robin arbitration, drives the unit's START/READY handshake, answers
// divide special cases locally, and holds each result on a per-port
// response interface until the consumer accepts it.
//   CLK, RST                      : clock, synchronous active-high reset
//   REQn_VALID/READY/M_CNT/RS1/RS2/TAG : request port n (n = 0, 1)
//   RSPn_VALID/DATA/TAG/ACCEPT    : response port n
//   MU_START/M_CNT/RS1/RS2        : drive the shared unit
//   MU_OUT, MU_READY              : unit result and result-valid
//   BUSY                          : FSM is not idle
module rv32m_scheduler
  import rv32m_scheduler_pkg::*;
#(
  parameter int INPUT_WIDTH = 32,
  parameter int TAG_WIDTH   = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   REQ0_VALID,
  output logic                   REQ0_READY,
  input  logic [2:0]             REQ0_M_CNT,
  input  logic [INPUT_WIDTH-1:0] REQ0_RS1,
  input  logic [INPUT_WIDTH-1:0] REQ0_RS2,
  input  logic [TAG_WIDTH-1:0]   REQ0_TAG,
  input  logic                   REQ1_VALID,
  output logic                   REQ1_READY,
  input  logic [2:0]             REQ1_M_CNT,
  input  logic [INPUT_WIDTH-1:0] REQ1_RS1,
  input  logic [INPUT_WIDTH-1:0] REQ1_RS2,
  input  logic [TAG_WIDTH-1:0]   REQ1_TAG,
  output logic                   RSP0_VALID,
  output logic [INPUT_WIDTH-1:0] RSP0_DATA,
  output logic [TAG_WIDTH-1:0]   RSP0_TAG,
  input  logic                   RSP0_ACCEPT,
  output logic                   RSP1_VALID,
  output logic [INPUT_WIDTH-1:0] RSP1_DATA,
  output logic [TAG_WIDTH-1:0]   RSP1_TAG,
  input  logic                   RSP1_ACCEPT,
  output logic                   MU_START,
  output logic [2:0]             MU_M_CNT,
  output logic [INPUT_WIDTH-1:0] MU_RS1,
  output logic [INPUT_WIDTH-1:0] MU_RS2,
  input  logic [INPUT_WIDTH-1:0] MU_OUT,
  input  logic                   MU_READY,
  output logic                   BUSY
);

  logic [1:0]             state;
  logic                   last_port;    // 1: port 1 was granted most recently
  logic                   port_hold;    // port owning the operation in flight
  logic [TAG_WIDTH-1:0]   tag_hold;
  logic [INPUT_WIDTH-1:0] fast_result;

  logic                   in_idle;
  logic                   elig0, elig1, grant0, grant1, accept;
  logic [2:0]             req_m_cnt;
  logic [INPUT_WIDTH-1:0] req_rs1, req_rs2;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   sc_hit;
  logic [INPUT_WIDTH-1:0] sc_result;
  logic                   rsp_done;
  logic [INPUT_WIDTH-1:0] rsp_data;

  // A port with an unaccepted response may not issue; this also keeps a port
  // ineligible during the cycle its response is being cleared.
  assign elig0   = REQ0_VALID && !RSP0_VALID;
  assign elig1   = REQ1_VALID && !RSP1_VALID;
  assign grant0  = elig0 && (!elig1 || last_port);
  assign grant1  = elig1 && (!elig0 || !last_port);
  assign in_idle = (state == ST_IDLE);

  assign REQ0_READY = in_idle && grant0 && !RST;
  assign REQ1_READY = in_idle && grant1 && !RST;
  assign accept     = REQ0_READY || REQ1_READY;
  assign BUSY       = !in_idle;

  always_comb begin
    req_m_cnt = REQ0_M_CNT;
    req_rs1   = REQ0_RS1;
    req_rs2   = REQ0_RS2;
    req_tag   = REQ0_TAG;
    if (REQ1_READY) begin
      req_m_cnt = REQ1_M_CNT;
      req_rs1   = REQ1_RS1;
      req_rs2   = REQ1_RS2;
      req_tag   = REQ1_TAG;
    end
  end

  m_special_case #(
    .INPUT_WIDTH(INPUT_WIDTH)
  ) u_special_case (
    .M_CNT (req_m_cnt),
    .RS1   (req_rs1),
    .RS2   (req_rs2),
    .HIT   (sc_hit),
    .RESULT(sc_result)
  );

  // MU_READY only counts while the FSM is waiting on the unit.
  assign rsp_done = (state == ST_FAST) || ((state == ST_EXEC) && MU_READY);
  assign rsp_data = (state == ST_FAST) ? fast_result : MU_OUT;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      last_port   <= 1'b1;
      port_hold   <= 1'b0;
      tag_hold    <= '0;
      fast_result <= '0;
      MU_START    <= 1'b0;
      MU_M_CNT    <= '0;
      MU_RS1      <= '0;
      MU_RS2      <= '0;
      RSP0_VALID  <= 1'b0;
      RSP0_DATA   <= '0;
      RSP0_TAG    <= '0;
      RSP1_VALID  <= 1'b0;
      RSP1_DATA   <= '0;
      RSP1_TAG    <= '0;
    end else begin
      if (RSP0_ACCEPT) RSP0_VALID <= 1'b0;
      if (RSP1_ACCEPT) RSP1_VALID <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            MU_M_CNT    <= req_m_cnt;
            MU_RS1      <= req_rs1;
            MU_RS2      <= req_rs2;
            tag_hold    <= req_tag;
            port_hold   <= REQ1_READY;
            last_port   <= REQ1_READY;
            fast_result <= sc_result;
            if (sc_hit) begin
              state <= ST_FAST;
            end else begin
              state    <= ST_EXEC;
              MU_START <= 1'b1;
            end
          end
        end
        ST_FAST: state <= ST_IDLE;
        ST_EXEC: begin
          if (MU_READY) begin
            MU_START <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A port cannot hold a valid response while its own op is in flight,
      // so this write never collides with the accept-clear above.
      if (rsp_done) begin
        if (port_hold) begin
          RSP1_VALID <= 1'b1;
          RSP1_DATA  <= rsp_data;
          RSP1_TAG   <= tag_hold;
        end else begin
          RSP0_VALID <= 1'b1;
          RSP0_DATA  <= rsp_data;
          RSP0_TAG   <= tag_hold;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32m_scheduler.sv
// Self-checking bench for rv32m_scheduler: a behavioural RV32M unit with
// random latency sits behind the scheduler, and a RISC-V-level reference
// function predicts every response.
module tb_rv32m_scheduler;

  localparam int W  = 32;
  localparam int TW = 5;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic CLK = 1'b0;
  logic RST;
  logic REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [2:0] REQ0_M_CNT, REQ1_M_CNT;
  logic [W-1:0] REQ0_RS1, REQ0_RS2, REQ1_RS1, REQ1_RS2;
  logic [TW-1:0] REQ0_TAG, REQ1_TAG;
  logic RSP0_VALID, RSP1_VALID, RSP0_ACCEPT, RSP1_ACCEPT;
  logic [W-1:0] RSP0_DATA, RSP1_DATA;
  logic [TW-1:0] RSP0_TAG, RSP1_TAG;
  logic MU_START, MU_READY, BUSY;
  logic [2:0] MU_M_CNT;
  logic [W-1:0] MU_RS1, MU_RS2, MU_OUT;

  always #5 CLK = ~CLK;

  rv32m_scheduler #(.INPUT_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_M_CNT(REQ0_M_CNT),
    .REQ0_RS1(REQ0_RS1), .REQ0_RS2(REQ0_RS2), .REQ0_TAG(REQ0_TAG),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_M_CNT(REQ1_M_CNT),
    .REQ1_RS1(REQ1_RS1), .REQ1_RS2(REQ1_RS2), .REQ1_TAG(REQ1_TAG),
    .RSP0_VALID(RSP0_VALID), .RSP0_DATA(RSP0_DATA), .RSP0_TAG(RSP0_TAG), .RSP0_ACCEPT(RSP0_ACCEPT),
    .RSP1_VALID(RSP1_VALID), .RSP1_DATA(RSP1_DATA), .RSP1_TAG(RSP1_TAG), .RSP1_ACCEPT(RSP1_ACCEPT),
    .MU_START(MU_START), .MU_M_CNT(MU_M_CNT), .MU_RS1(MU_RS1), .MU_RS2(MU_RS2),
    .MU_OUT(MU_OUT), .MU_READY(MU_READY), .BUSY(BUSY)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics, including the divide corner cases.
  function automatic logic [31:0] ref_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, sa, sb, p;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      OP_MUL:    begin p = ua * ub; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      OP_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Behavioural multiply/divide unit: captures operands on START, answers
  // after a random delay with a one-cycle READY, then waits for START to drop.
  logic         unit_ready, stray_ready;
  logic [W-1:0] unit_out;
  logic         u_busy, u_wait;
  int           u_cnt;
  logic [2:0]   u_op;
  logic [W-1:0] u_a, u_b;
  int           lat_override = 0;

  assign MU_READY = unit_ready | stray_ready;
  assign MU_OUT   = unit_out;

  always @(posedge CLK) begin
    if (RST) begin
      u_busy     <= 1'b0;
      u_wait     <= 1'b0;
      unit_ready <= 1'b0;
      unit_out   <= '0;
    end else begin
      unit_ready <= 1'b0;
      if (u_wait) begin
        if (!MU_START) u_wait <= 1'b0;
      end else if (u_busy) begin
        if (u_cnt == 0) begin
          unit_ready <= 1'b1;
          unit_out   <= ref_m(u_op, u_a, u_b);
          u_busy     <= 1'b0;
          u_wait     <= 1'b1;
        end else begin
          u_cnt <= u_cnt - 1;
        end
      end else if (MU_START) begin
        u_busy <= 1'b1;
        u_op   <= MU_M_CNT;
        u_a    <= MU_RS1;
        u_b    <= MU_RS2;
        u_cnt  <= (lat_override > 0) ? lat_override : int'($urandom_range(0, 3));
      end
    end
  end

  // Scoreboard: predict on every accepted request, compare on every
  // consumed response, and watch the unit-side handshake.
  logic [36:0] q0[$];
  logic [36:0] q1[$];
  int          grants[$];
  int          mu_start_cnt = 0;
  int          rsp_rise0 = 0, rsp_rise1 = 0;
  logic        prev_start = 1'b0, prev_v0 = 1'b0, prev_v1 = 1'b0;
  logic [2:0]  prev_cnt;
  logic [W-1:0] prev_rs1, prev_rs2;

  always @(negedge CLK) begin
    if (RST) begin
      q0.delete();
      q1.delete();
      prev_start <= 1'b0;
    end else begin
      if (MU_START) mu_start_cnt <= mu_start_cnt + 1;
      if (prev_start && MU_START) begin
        check_eq("mu_m_cnt_stable", 64'(MU_M_CNT), 64'(prev_cnt));
        check_eq("mu_rs1_stable", 64'(MU_RS1), 64'(prev_rs1));
        check_eq("mu_rs2_stable", 64'(MU_RS2), 64'(prev_rs2));
      end
      prev_start <= MU_START;
      prev_cnt   <= MU_M_CNT;
      prev_rs1   <= MU_RS1;
      prev_rs2   <= MU_RS2;
      if (REQ0_READY || REQ1_READY) begin
        check_eq("single_grant", 64'(REQ0_READY && REQ1_READY), 64'(0));
        check_eq("ready_only_idle", 64'(BUSY), 64'(0));
      end
      if (REQ0_VALID && REQ0_READY) begin
        q0.push_back({REQ0_TAG, ref_m(REQ0_M_CNT, REQ0_RS1, REQ0_RS2)});
        grants.push_back(0);
      end
      if (REQ1_VALID && REQ1_READY) begin
        q1.push_back({REQ1_TAG, ref_m(REQ1_M_CNT, REQ1_RS1, REQ1_RS2)});
        grants.push_back(1);
      end
      if (RSP0_VALID && !prev_v0) rsp_rise0 <= rsp_rise0 + 1;
      if (RSP1_VALID && !prev_v1) rsp_rise1 <= rsp_rise1 + 1;
      if (RSP0_VALID && RSP0_ACCEPT) begin
        if (q0.size() == 0) check_eq("rsp0_unexpected", 64'(1), 64'(0));
        else begin
          check_eq("rsp0_data", 64'(RSP0_DATA), 64'(q0[0][31:0]));
          check_eq("rsp0_tag", 64'(RSP0_TAG), 64'(q0[0][36:32]));
          void'(q0.pop_front());
        end
      end
      if (RSP1_VALID && RSP1_ACCEPT) begin
        if (q1.size() == 0) check_eq("rsp1_unexpected", 64'(1), 64'(0));
        else begin
          check_eq("rsp1_data", 64'(RSP1_DATA), 64'(q1[0][31:0]));
          check_eq("rsp1_tag", 64'(RSP1_TAG), 64'(q1[0][36:32]));
          void'(q1.pop_front());
        end
      end
    end
    prev_v0 <= RSP0_VALID;
    prev_v1 <= RSP1_VALID;
  end

  task automatic issue(input int p, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    int n = 0;
    @(posedge CLK); #1;
    if (p == 0) begin
      REQ0_VALID = 1'b1; REQ0_M_CNT = op; REQ0_RS1 = a; REQ0_RS2 = b; REQ0_TAG = tag;
    end else begin
      REQ1_VALID = 1'b1; REQ1_M_CNT = op; REQ1_RS1 = a; REQ1_RS2 = b; REQ1_TAG = tag;
    end
    forever begin
      @(negedge CLK);
      if ((p == 0 && REQ0_READY) || (p == 1 && REQ1_READY)) break;
      n++;
      if (n > 300) begin
        check_eq($sformatf("issue%0d_timeout", p), 64'(0), 64'(1));
        break;
      end
    end
    @(posedge CLK); #1;
    if (p == 0) REQ0_VALID = 1'b0;
    else        REQ1_VALID = 1'b0;
  endtask

  task automatic wait_rsp(input int p, output int n);
    n = 0;
    forever begin
      @(negedge CLK);
      n++;
      if ((p == 0 && RSP0_VALID) || (p == 1 && RSP1_VALID)) break;
      if (n > 200) begin
        check_eq($sformatf("rsp%0d_timeout", p), 64'(0), 64'(1));
        break;
      end
    end
  endtask

  task automatic random_port(input int p, input int count);
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < count; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      issue(p, op, a, b, 5'($urandom_range(0, 31)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0, s1, r0, r1, done;
    RST = 1'b1;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    REQ0_M_CNT = OP_MUL; REQ1_M_CNT = OP_MUL;
    REQ0_RS1 = 32'd1; REQ0_RS2 = 32'd1; REQ1_RS1 = 32'd1; REQ1_RS2 = 32'd1;
    REQ0_TAG = '0; REQ1_TAG = '0;
    RSP0_ACCEPT = 1'b1; RSP1_ACCEPT = 1'b1;
    stray_ready = 1'b0;

    // Reset state, with requests asserted to show they are not accepted.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_req0_ready", 64'(REQ0_READY), 64'(0));
    check_eq("rst_req1_ready", 64'(REQ1_READY), 64'(0));
    check_eq("rst_mu_start", 64'(MU_START), 64'(0));
    check_eq("rst_busy", 64'(BUSY), 64'(0));
    check_eq("rst_rsp0_valid", 64'(RSP0_VALID), 64'(0));
    check_eq("rst_rsp1_valid", 64'(RSP1_VALID), 64'(0));
    check_eq("rst_rsp0_data", 64'(RSP0_DATA), 64'(0));
    check_eq("rst_rsp1_tag", 64'(RSP1_TAG), 64'(0));
    check_eq("rst_mu_rs1", 64'(MU_RS1), 64'(0));
    check_eq("rst_mu_m_cnt", 64'(MU_M_CNT), 64'(0));
    @(posedge CLK); #1;
    RST = 1'b0; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;

    // mul on port 0 through the unit.
    r1 = rsp_rise1;
    issue(0, OP_MUL, 32'd7, 32'd6, 5'd3);
    begin : mul_wait
      bit got = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge CLK);
        if (RSP0_VALID) begin got = 1'b1; break; end
        check_eq("mu_start_hold", 64'(MU_START), 64'(1));
        check_eq("busy_exec", 64'(BUSY), 64'(1));
      end
      check_eq("mul_rsp_seen", 64'(got), 64'(1));
    end
    check_eq("mul_data", 64'(RSP0_DATA), 64'(42));
    check_eq("mul_tag", 64'(RSP0_TAG), 64'(3));
    check_eq("mul_start_fell", 64'(MU_START), 64'(0));
    check_eq("mul_rsp1_quiet", 64'(rsp_rise1), 64'(r1));

    // Special cases answered locally in two cycles, never starting the unit.
    s0 = mu_start_cnt;
    issue(1, OP_DIVU, 32'd100, 32'd0, 5'd9);
    wait_rsp(1, n);
    check_eq("divu0_latency", 64'(n), 64'(2));
    check_eq("divu0_data", 64'(RSP1_DATA), 64'hFFFF_FFFF);
    check_eq("divu0_tag", 64'(RSP1_TAG), 64'(9));
    issue(1, OP_REMU, 32'd100, 32'd0, 5'd10);
    wait_rsp(1, n);
    check_eq("remu0_latency", 64'(n), 64'(2));
    check_eq("remu0_data", 64'(RSP1_DATA), 64'(100));
    issue(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    wait_rsp(0, n);
    check_eq("div_ovf_latency", 64'(n), 64'(2));
    check_eq("div_ovf_data", 64'(RSP0_DATA), 64'h8000_0000);
    issue(0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    wait_rsp(0, n);
    check_eq("rem_ovf_data", 64'(RSP0_DATA), 64'(0));
    check_eq("rem_ovf_tag", 64'(RSP0_TAG), 64'(12));
    @(negedge CLK);
    check_eq("fast_no_start", 64'(mu_start_cnt), 64'(s0));

    // Stray READY while idle must not produce a response.
    @(posedge CLK); #1;
    stray_ready = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check_eq("stray_rsp0", 64'(RSP0_VALID), 64'(0));
      check_eq("stray_rsp1", 64'(RSP1_VALID), 64'(0));
      check_eq("stray_busy", 64'(BUSY), 64'(0));
    end
    @(posedge CLK); #1;
    stray_ready = 1'b0;

    // Both ports saturated: grants alternate, starting with port 0.
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    grants.delete();
    fork
      for (int i = 0; i < 4; i++) issue(0, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(i));
      for (int i = 0; i < 4; i++) issue(1, OP_REM, 32'hFFFF_FFF9, 32'd2, 5'(16 + i));
    join
    repeat (20) @(posedge CLK);
    check_eq("rr_grant_count", 64'(grants.size()), 64'(8));
    for (int i = 0; i < 8 && i < grants.size(); i++)
      check_eq($sformatf("rr_grant_%0d", i), 64'(grants[i]), 64'(i % 2));

    // Backpressure on port 0 while port 1 keeps working.
    @(posedge CLK); #1;
    RSP0_ACCEPT = 1'b0;
    issue(0, OP_MUL, 32'd7, 32'd6, 5'd1);
    wait_rsp(0, n);
    check_eq("bp_first_data", 64'(RSP0_DATA), 64'(42));
    fork
      issue(0, OP_MUL, 32'd5, 32'd5, 5'd2);
      for (int i = 0; i < 3; i++) issue(1, OP_DIVU, $urandom(), $urandom() | 32'd1, 5'(i));
      begin
        r1 = rsp_rise1;
        repeat (10) begin
          @(negedge CLK);
          check_eq("bp_req0_ready", 64'(REQ0_READY), 64'(0));
          check_eq("bp_rsp0_valid", 64'(RSP0_VALID), 64'(1));
          check_eq("bp_rsp0_data", 64'(RSP0_DATA), 64'(42));
          check_eq("bp_rsp0_tag", 64'(RSP0_TAG), 64'(1));
        end
        check_eq("bp_port1_progress", 64'(rsp_rise1 > r1), 64'(1));
        @(posedge CLK); #1;
        RSP0_ACCEPT = 1'b1;
      end
    join
    repeat (20) @(posedge CLK);

    // Reset during EXEC drops the operation.
    lat_override = 30;
    r0 = rsp_rise0;
    issue(0, OP_DIV, 32'd1000, 32'd7, 5'd4);
    @(negedge CLK);
    check_eq("rst_exec_started", 64'(MU_START), 64'(1));
    repeat (3) @(negedge CLK);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    lat_override = 0;
    @(negedge CLK);
    check_eq("rst_exec_start_low", 64'(MU_START), 64'(0));
    check_eq("rst_exec_idle", 64'(BUSY), 64'(0));
    repeat (10) @(negedge CLK);
    check_eq("rst_exec_no_rsp", 64'(rsp_rise0), 64'(r0));
    issue(0, OP_DIV, 32'd1000, 32'd7, 5'd5);
    wait_rsp(0, n);
    check_eq("div_after_rst_data", 64'(RSP0_DATA), 64'(142));
    check_eq("div_after_rst_tag", 64'(RSP0_TAG), 64'(5));

    // Randomized traffic on both ports with random response acceptance.
    done = 0;
    fork
      begin random_port(0, 30); done++; end
      begin random_port(1, 30); done++; end
      while (done < 2) begin
        @(posedge CLK); #1;
        RSP0_ACCEPT = ($urandom_range(0, 3) != 0);
        RSP1_ACCEPT = ($urandom_range(0, 3) != 0);
      end
    join
    @(posedge CLK); #1;
    RSP0_ACCEPT = 1'b1;
    RSP1_ACCEPT = 1'b1;
    repeat (40) @(posedge CLK);
    @(negedge CLK);
    check_eq("drain_q0", 64'(q0.size()), 64'(0));
    check_eq("drain_q1", 64'(q1.size()), 64'(0));
    check_eq("drain_idle", 64'(BUSY), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32m_scheduler.md
Name: rv32m_scheduler

Overview:
- Shares one RV32M multiply/divide unit between two requesters (port 0: integer pipeline EX stage; port 1: secondary issue path) using round-robin arbitration.
- Sequences the unit's START/READY protocol and holds operands stable for the whole operation.
- Resolves RISC-V divide special cases (divide-by-zero, signed overflow) locally without invoking the unit.
- Returns each result, with its tag, on a per-requester response port that holds until accepted.

Parameters:
- INPUT_WIDTH, 32, operand/result width.
- TAG_WIDTH, 5, requester tag width (destination register index).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ0_VALID / REQ1_VALID  in  1  request present.
- REQ0_READY / REQ1_READY  out  1  request accepted this cycle when high together with VALID.
- REQ0_M_CNT / REQ1_M_CNT  in  3  op: mul=0, mulh=1, mulhsu=2, mulhu=3, div=4, divu=5, rem=6, remu=7.
- REQ0_RS1, REQ0_RS2 / REQ1_RS1, REQ1_RS2  in  INPUT_WIDTH  operands.
- REQ0_TAG / REQ1_TAG  in  TAG_WIDTH  returned unchanged with the result.
- RSP0_VALID / RSP1_VALID  out  1  result held.
- RSP0_DATA / RSP1_DATA  out  INPUT_WIDTH  result.
- RSP0_TAG / RSP1_TAG  out  TAG_WIDTH  tag of the result.
- RSP0_ACCEPT / RSP1_ACCEPT  in  1  consumer takes the response.
- MU_START  out  1  drives the unit's START.
- MU_M_CNT  out  3  drives the unit's M_CNT.
- MU_RS1, MU_RS2  out  INPUT_WIDTH  drive the unit's operands.
- MU_OUT  in  INPUT_WIDTH  unit result.
- MU_READY  in  1  unit result valid.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset values:
  - state=IDLE; MU_START=0; RSPn_VALID=0; REQn_READY=0; BUSY=0.
  - RR pointer favours port 0.
  - RSPn_DATA/TAG=0; MU_M_CNT/RS1/RS2=0.
- States: IDLE, EXEC, FAST.
- IDLE:
  - Port n is eligible if REQn_VALID=1 and RSPn_VALID=0 (one outstanding op per port).
  - If both ports are eligible, grant the port not granted last; otherwise grant the single eligible port.
  - REQn_READY is combinational, high only in IDLE for the granted port.
  - On accept, latch op/operands/tag/port into MU_* and holding registers.
  - Next state is FAST if the special-case condition holds, else EXEC.
- Special cases (div/divu/rem/remu only):
  - RS2=0: div/divu result=all-ones; rem/remu result=RS1.
  - div/rem with RS1=0x80000000 and RS2=0xFFFFFFFF: div result=0x80000000; rem result=0.
- FAST:
  - Lasts one cycle; MU_START stays 0.
  - Writes the result to the granted port's response registers, sets RSPn_VALID, then returns to IDLE.
- EXEC:
  - MU_START=1; MU_M_CNT/RS1/RS2 held constant for every cycle of EXEC.
  - Each cycle, check MU_READY. When MU_READY=1, capture MU_OUT into RSPn_DATA and set RSPn_VALID at that edge.
  - At the same edge MU_START falls and the state returns to IDLE.
  - No timeout.
  - Only MU_READY sampled while in EXEC counts; READY outside EXEC is ignored.
- Latency:
  - Accept at edge t; MU_START high from t+1.
  - RSP valid one edge after the MU_READY cycle.
  - FAST path: RSP valid at edge t+2.
- Response:
  - RSPn_VALID/DATA/TAG hold until a cycle with RSPn_ACCEPT=1, which clears VALID at that edge.
  - RSPn_ACCEPT while VALID=0 is ignored.
  - In the clearing cycle port n is not yet eligible; it becomes eligible the next cycle (no same-cycle refill).
- Back-to-back: IDLE lasts at least one cycle between operations, so the unit always sees START drop before a new op.
- RR pointer updates only on an accept.
- Reset mid-EXEC: the operation is dropped and no response is produced; MU_START=0 after the reset edge.
- RST dominates accept and ACCEPT in the same cycle.

Decomposition:
- Shared parameter header (the existing pipeline params include) holds the M_CNT encodings mul..remu and the state encodings IDLE/EXEC/FAST.
- One combinational sub-module, m_special_case: inputs M_CNT, RS1, RS2; outputs HIT and RESULT.
- Arbiter and FSM stay in rv32m_scheduler.

Test Plan:
- Bench uses the real RV32M instance as the unit.
- mul, port 0: RS1=7, RS2=6, TAG=3 -> MU_START high until MU_READY; RSP0 DATA=42, TAG=3; RSP1 never valid.
- divu, port 1: RS1=100, RS2=0 -> FAST; RSP1 DATA=0xFFFFFFFF at edge t+2; MU_START never 1. Repeat with remu -> DATA=100.
- div then rem: RS1=0x80000000, RS2=0xFFFFFFFF -> DATA=0x80000000, then DATA=0; no MU_START.
- Both ports request continuously with ACCEPT held high:
  - port 0: mulhu 0xFFFFFFFF*0xFFFFFFFF;
  - port 1: rem -7,2;
  - grants alternate 0,1,0,1; port 0 results 0xFFFFFFFE; port 1 results 0xFFFFFFFF.
- Backpressure: RSP0_ACCEPT=0 for 10 cycles with REQ0_VALID held -> REQ0_READY stays 0, RSP0 stable; port 1 ops proceed meanwhile.
- RST pulsed during EXEC of div 1000/7 -> no RSP; MU_START=0 after the edge. A subsequent div 1000/7 returns 142.
